// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: per-key FSM encoding and default timing constants.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } key_fsm_e;

  // 20 ms debounce and 1 s long-press at a 50 MHz clock
  localparam int DEF_N_KEYS       = 4;
  localparam int DEF_DEBOUNCE_CYC = 1000000;
  localparam int DEF_LONG_CYC     = 50000000;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM with its counter, hold counter and event pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam int HW = $clog2(LONG_CYC);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);

  logic [1:0]    sync_q, sync_d;
  key_fsm_e      state_q, state_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          long_done_q, long_done_d;
  logic          key_state_q, key_state_d;
  logic          key_press_q, key_press_d;
  logic          key_release_q, key_release_d;
  logic          key_long_q, key_long_d;
  logic          key_s;

  assign key_s  = sync_q[1];
  assign sync_d = {sync_q[0], key_n};

  // The sample that triggers leaving a stable state already counts as the
  // first cycle of the debounce window, so the window spans DEBOUNCE_CYC samples.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d  = DB_PRESS;
          db_cnt_d = DW'(1);
        end
      end
      DB_PRESS: begin
        if (key_s) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DW'(1);
        end
      end
      HELD: begin
        if (key_s) begin
          state_d  = DB_REL;
          db_cnt_d = DW'(1);
        end
      end
      DB_REL: begin
        if (!key_s) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    key_state_d   = (state_d == HELD) || (state_d == DB_REL);
    key_press_d   = key_state_d && !key_state_q;
    key_release_d = !key_state_d && key_state_q;
    key_long_d    = key_state_q && (hold_q == HOLD_LAST) && !long_done_q;
    hold_d        = hold_q;
    long_done_d   = long_done_q;
    if (key_press_d) begin
      hold_d      = '0;
      long_done_d = 1'b0;
    end else begin
      if (key_state_q && (hold_q != HOLD_LAST)) hold_d = hold_q + HW'(1);
      if (key_long_d) long_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= 2'b11;
      state_q       <= IDLE;
      db_cnt_q      <= '0;
      hold_q        <= '0;
      long_done_q   <= 1'b0;
      key_state_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_long_q    <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      hold_q        <= hold_d;
      long_done_q   <= long_done_d;
      key_state_q   <= key_state_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      key_long_q    <= key_long_d;
    end
  end

  assign key_state   = key_state_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign key_long    = key_long_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces N active-low push-buttons into clean key levels plus press/release/long-press pulses.
module key_debounce
  import key_pkg::*;
#(
  parameter int N_KEYS       = DEF_N_KEYS,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_n      (key_n[g]),
      .key_state  (key_state[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g]),
      .key_long   (key_long[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: every event pulse is matched against a queue of expected (cycle, outputs) records.
module tb_key_debounce;

  localparam int N = 4;
  localparam int D = 8;
  localparam int L = 32;
  localparam int W = 48;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] key_n;
  logic [N-1:0] key_state, key_press, key_release, key_long;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];

  key_debounce #(
    .N_KEYS      (N),
    .DEBOUNCE_CYC(D),
    .LONG_CYC    (L)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] pack_ev(int c, logic [3:0] p, logic [3:0] r,
                                           logic [3:0] l, logic [3:0] s);
    return {32'(c), p, r, l, s};
  endfunction

  // driver / scoreboard helpers
  task automatic expect_ev(int c, logic [3:0] p, logic [3:0] r, logic [3:0] l, logic [3:0] s);
    exp_q.push_back(pack_ev(c, p, r, l, s));
  endtask

  task automatic check4(string tag, logic [3:0] obs, logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic check_drained(string tag);
    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL %s pending=%0d exp=0", tag, exp_q.size());
    end
  endtask

  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  // scoreboard: any cycle carrying a pulse must match the head of the queue
  always @(negedge clk) begin : sb
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    if (rst_n === 1'b1 && (|{key_press, key_release, key_long})) begin
      obs = pack_ev(cyc, key_press, key_release, key_long, key_state);
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_event obs=%h exp=none", obs);
      end
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        tests++;
        assert (obs === exp) else begin
          fails++;
          $error("FAIL event cyc/p/r/l/s obs=%h exp=%h", obs, exp);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    key_n = '1;
    wait_cyc(3);
    check4("rst_state", key_state, 4'b0000);
    check4("rst_press", key_press, 4'b0000);
    check4("rst_release", key_release, 4'b0000);
    check4("rst_long", key_long, 4'b0000);
    rst_n = 1'b1;

    // clean press on key 0, released before the long-press point
    wait_cyc(1);
    key_n[0] = 1'b0;
    expect_ev(cyc + 10, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    wait_cyc(9);
    check4("t1_state_before", key_state, 4'b0000);
    wait_cyc(3);
    check4("t1_state", key_state, 4'b0001);
    wait_cyc(13);
    key_n[0] = 1'b1;
    expect_ev(cyc + 10, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    wait_cyc(15);
    check4("t1_state_rel", key_state, 4'b0000);

    // bounce on key 1: 5 low, 1 high, then held low
    key_n[1] = 1'b0;
    wait_cyc(5);
    key_n[1] = 1'b1;
    wait_cyc(1);
    key_n[1] = 1'b0;
    expect_ev(cyc + 10, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    wait_cyc(12);
    check4("t2_state", key_state, 4'b0010);
    wait_cyc(8);
    key_n[1] = 1'b1;
    expect_ev(cyc + 10, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    wait_cyc(15);

    // long press on key 2
    key_n[2] = 1'b0;
    expect_ev(cyc + 10, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    expect_ev(cyc + 10 + L, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    wait_cyc(60);
    check4("t3_state", key_state, 4'b0100);
    key_n[2] = 1'b1;
    expect_ev(cyc + 10, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    wait_cyc(15);
    check4("t3_state_rel", key_state, 4'b0000);

    // glitch on key 3 one sample shorter than the debounce window
    key_n[3] = 1'b0;
    wait_cyc(D - 1);
    key_n[3] = 1'b1;
    wait_cyc(15);
    check4("t4_state", key_state, 4'b0000);
    check_drained("t4_drained");

    // all keys at once
    key_n = 4'b0000;
    expect_ev(cyc + 10, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
    wait_cyc(12);
    check4("t5_state", key_state, 4'b1111);
    wait_cyc(3);
    key_n = 4'b1111;
    expect_ev(cyc + 10, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
    wait_cyc(15);

    // reset while key 0 is held
    key_n[0] = 1'b0;
    expect_ev(cyc + 10, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    wait_cyc(15);
    check4("t6_state_held", key_state, 4'b0001);
    rst_n = 1'b0;
    #1;
    check4("t6_rst_state", key_state, 4'b0000);
    check4("t6_rst_press", key_press, 4'b0000);
    check4("t6_rst_release", key_release, 4'b0000);
    check4("t6_rst_long", key_long, 4'b0000);
    wait_cyc(2);
    rst_n = 1'b1;
    expect_ev(cyc + 10, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    wait_cyc(12);
    check4("t6_state_repress", key_state, 4'b0001);
    key_n[0] = 1'b1;
    expect_ev(cyc + 10, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    wait_cyc(15);

    check_drained("final_drained");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
